// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-RAM arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        DMA  = 2'd2
    } arb_state_e;

    localparam int WAIT_W = 5;

    // Wide enough to hold the saturation value itself.
    function automatic int starve_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Loadable wait-state down-counter; `last` marks the access completion cycle.
module dmem_wait_cnt
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              last
);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign last = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the core memory stage and the DMA port,
// inserting wait states and stalling the pipeline while the core waits.
//
//   state | meaning
//   IDLE  | arbitrate; zero-wait core accesses complete here
//   CORE  | core owns the RAM, counting down wait states
//   DMA   | captured DMA request owns the RAM, counting down
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int WAIT_CYC   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    input  logic              dma_valid_i,
    output logic              dma_ready_o,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    localparam int SW = starve_w(STARVE_MAX);
    localparam logic [WAIT_W-1:0] CORE_LOAD = WAIT_W'(WAIT_CYC);
    localparam logic [WAIT_W-1:0] DMA_LOAD  = WAIT_W'(WAIT_CYC + 1);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              dma_we_q;
    logic [ADDR_W-1:0] dma_addr_q;
    logic [DATA_W-1:0] dma_wdata_q;

    logic              cnt_load;
    logic [WAIT_W-1:0] cnt_load_val;
    logic              cnt_dec;
    logic              cnt_last;

    logic              core_wins;
    logic              core_done;
    logic              dma_rd_done;

    dmem_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    assign core_wins = core_req_i && (!dma_valid_i || starve_q < SW'(STARVE_MAX));

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = CORE_LOAD;
        cnt_dec      = 1'b0;
        ram_addr_o   = core_addr_i;
        ram_wdata_o  = core_wdata_i;
        ram_we_o     = 1'b0;
        core_done    = 1'b0;
        dma_ready_o  = 1'b0;
        dma_rd_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_wins) begin
                    if (WAIT_CYC == 0) begin
                        core_done = 1'b1;
                        ram_we_o  = core_we_i;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = CORE_LOAD;
                        state_d      = CORE;
                    end
                end else if (dma_valid_i) begin
                    // Acceptance cycle only captures; the RAM is driven from DMA state.
                    dma_ready_o  = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = DMA_LOAD;
                    state_d      = DMA;
                end
            end
            CORE: begin
                if (!core_req_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        core_done = 1'b1;
                        ram_we_o  = core_we_i;
                        state_d   = IDLE;
                    end
                end
            end
            DMA: begin
                ram_addr_o  = dma_addr_q;
                ram_wdata_o = dma_wdata_q;
                cnt_dec     = 1'b1;
                if (cnt_last) begin
                    ram_we_o    = dma_we_q;
                    dma_rd_done = !dma_we_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!dma_valid_i || dma_ready_o)
            starve_d = '0;
        else if (core_done && starve_q < SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    assign core_rdata_o = ram_rdata_i;
    assign core_stall_o = core_req_i && !core_done;
    assign busy_o       = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            dma_we_q     <= 1'b0;
            dma_addr_q   <= '0;
            dma_wdata_q  <= '0;
            dma_rvalid_o <= 1'b0;
            dma_rdata_o  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            dma_rvalid_o <= dma_rd_done;
            if (dma_ready_o) begin
                dma_we_q    <= dma_we_i;
                dma_addr_q  <= dma_addr_i;
                dma_wdata_q <= dma_wdata_i;
            end
            if (dma_rd_done)
                dma_rdata_o <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: four arbiters (WAIT_CYC 0..3) share stimulus, each with its own RAM.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        dma_valid = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;

    logic [3:0][31:0] core_rdata, dma_rdata, ram_addr, ram_wdata;
    logic [3:0]       core_stall, dma_ready, dma_rvalid, ram_we, busy;

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [31:0] mem [0:255];
        logic [31:0] rdata;

        assign rdata = mem[ram_addr[g][9:2]];
        always @(posedge clk) if (ram_we[g]) mem[ram_addr[g][9:2]] <= ram_wdata[g];

        dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYC(g), .STARVE_MAX(4)) dut (
            .clk          (clk),
            .reset        (reset),
            .core_req_i   (core_req),
            .core_we_i    (core_we),
            .core_addr_i  (core_addr),
            .core_wdata_i (core_wdata),
            .core_rdata_o (core_rdata[g]),
            .core_stall_o (core_stall[g]),
            .dma_valid_i  (dma_valid),
            .dma_ready_o  (dma_ready[g]),
            .dma_we_i     (dma_we),
            .dma_addr_i   (dma_addr),
            .dma_wdata_i  (dma_wdata),
            .dma_rvalid_o (dma_rvalid[g]),
            .dma_rdata_o  (dma_rdata[g]),
            .ram_addr_o   (ram_addr[g]),
            .ram_wdata_o  (ram_wdata[g]),
            .ram_we_o     (ram_we[g]),
            .ram_rdata_i  (rdata),
            .busy_o       (busy[g])
        );
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req  = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_valid = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (busy[i] !== 1'b0 || dma_rvalid[i] !== 1'b0 || dma_rdata[i] !== 32'h0 ||
                dma_ready[i] !== 1'b0 || core_stall[i] !== 1'b0 || ram_we[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: busy=%b rvalid=%b rdata=%h ready=%b stall=%b we=%b, expected all zero",
                         i, busy[i], dma_rvalid[i], dma_rdata[i], dma_ready[i], core_stall[i], ram_we[i]);
            end
        end
    endtask

    // WAIT_CYC=0: store then load at 0x10, both complete in their own cycle.
    task automatic test_core_zero_wait();
        do_reset();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (core_stall[0] !== 1'b0 || ram_we[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL w0_store: stall=%b we=%b, expected stall=0 we=1", core_stall[0], ram_we[0]);
        end
        cyc();
        core_we = 1'b0; core_wdata = '0;
        #1;
        n_tests++;
        if (core_rdata[0] !== 32'hDEADBEEF || core_stall[0] !== 1'b0 || ram_we[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL w0_load: rdata=%h stall=%b we=%b, expected DEADBEEF 0 0",
                     core_rdata[0], core_stall[0], ram_we[0]);
        end
        n_tests++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL w0_busy: busy=%b, expected 0", busy[0]);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    // WAIT_CYC=2: store 0x20 stalls two cycles, writes in the third.
    task automatic test_core_wait_store();
        do_reset();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h00001234;
        for (int c = 0; c < 3; c++) begin
            logic exp_stall, exp_we;
            exp_stall = (c < 2);
            exp_we    = (c == 2);
            #1;
            n_tests++;
            if (core_stall[2] !== exp_stall || ram_we[2] !== exp_we) begin
                n_fail++;
                $display("FAIL w2_store c%0d: stall=%b we=%b, expected stall=%b we=%b",
                         c, core_stall[2], ram_we[2], exp_stall, exp_we);
            end
            cyc();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (g_dut[2].mem[8] !== 32'h00001234 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL w2_store_result: mem=%h busy=%b, expected 00001234 0", g_dut[2].mem[8], busy[2]);
        end
        cyc();
    endtask

    // WAIT_CYC=1: DMA write 0x40 accepted c0, written c2; read accepted c3, rvalid c6.
    task automatic test_dma_write_read();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            logic exp_ready, exp_we, exp_rvalid;
            dma_valid = (c <= 3);
            dma_we    = (c == 0);
            dma_addr  = 32'h40;
            dma_wdata = (c == 0) ? 32'hCAFEF00D : 32'h0;
            exp_ready  = (c == 0 || c == 3);
            exp_we     = (c == 2);
            exp_rvalid = (c == 6);
            #1;
            n_tests++;
            if (dma_ready[1] !== exp_ready || ram_we[1] !== exp_we || dma_rvalid[1] !== exp_rvalid) begin
                n_fail++;
                $display("FAIL w1_dma c%0d: ready=%b we=%b rvalid=%b, expected %b %b %b",
                         c, dma_ready[1], ram_we[1], dma_rvalid[1], exp_ready, exp_we, exp_rvalid);
            end
            if (c == 2) begin
                n_tests++;
                if (ram_addr[1] !== 32'h40 || ram_wdata[1] !== 32'hCAFEF00D) begin
                    n_fail++;
                    $display("FAIL w1_dma_wr_bus: addr=%h wdata=%h, expected 40 CAFEF00D", ram_addr[1], ram_wdata[1]);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (dma_rdata[1] !== 32'hCAFEF00D) begin
                    n_fail++;
                    $display("FAIL w1_dma_rdata: got %h expected CAFEF00D", dma_rdata[1]);
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    // WAIT_CYC=0, both held: four core completions, DMA c4 (access c5), core resumes c6.
    task automatic test_starvation();
        int completions;
        do_reset();
        completions = 0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            logic exp_stall, exp_ready;
            exp_stall = (c == 4 || c == 5);
            exp_ready = (c == 4);
            #1;
            if (c < 6 && core_stall[0] === 1'b0) completions++;
            n_tests++;
            if (core_stall[0] !== exp_stall || dma_ready[0] !== exp_ready) begin
                n_fail++;
                $display("FAIL starve c%0d: stall=%b ready=%b, expected %b %b",
                         c, core_stall[0], dma_ready[0], exp_stall, exp_ready);
            end
            if (c == 6) begin
                n_tests++;
                if (dma_rvalid[0] !== 1'b1 || dma_rdata[0] !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL starve_dma_read: rvalid=%b rdata=%h, expected 1 DEADBEEF",
                             dma_rvalid[0], dma_rdata[0]);
                end
            end
            cyc();
        end
        n_tests++;
        if (completions != 4) begin
            n_fail++;
            $display("FAIL starve_count: got %0d completions before DMA, expected 4", completions);
        end
        idle_inputs();
        cyc();
    endtask

    // WAIT_CYC=3: simultaneous requests with starve_cnt=0, core goes first.
    task automatic test_same_cycle();
        do_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
        dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 32'h34;
        for (int c = 0; c < 5; c++) begin
            logic exp_stall, exp_ready;
            if (c == 4) core_req = 1'b0;
            exp_stall = (c < 3);
            exp_ready = (c == 4);
            #1;
            n_tests++;
            if (core_stall[3] !== exp_stall || dma_ready[3] !== exp_ready) begin
                n_fail++;
                $display("FAIL same_cycle c%0d: stall=%b ready=%b, expected %b %b",
                         c, core_stall[3], dma_ready[3], exp_stall, exp_ready);
            end
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    // WAIT_CYC=3: reset in the second DMA-state cycle of a write abandons it.
    task automatic test_reset_mid();
        int bad;
        do_reset();
        bad = 0;
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 32'h60; dma_wdata = 32'h000055AA;
        #1;
        n_tests++;
        if (dma_ready[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_accept: ready=%b expected 1", dma_ready[3]);
        end
        cyc();
        dma_valid = 1'b0; dma_we = 1'b0; dma_wdata = '0;
        if (ram_we[3] !== 1'b0) bad++;
        cyc();
        #1;
        n_tests++;
        if (busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_before: busy=%b expected 1", busy[3]);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy[3] !== 1'b0 || ram_we[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_now: busy=%b we=%b, expected 0 0", busy[3], ram_we[3]);
        end
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ram_we[3] !== 1'b0 || dma_rvalid[3] !== 1'b0 || busy[3] !== 1'b0) bad++;
            cyc();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_after: %0d cycles with write/rvalid/busy activity, expected 0", bad);
        end
        n_tests++;
        if (g_dut[3].mem[24] === 32'h000055AA) begin
            n_fail++;
            $display("FAIL mid_mem: mem=%h, abandoned write must not land", g_dut[3].mem[24]);
        end
    endtask

    initial begin
        test_reset();
        test_core_zero_wait();
        test_core_wait_store();
        test_dma_write_read();
        test_starvation();
        test_same_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
